rx_sync_ctrl: RTL and testbench
===============================

Name: rx_sync_ctrl

Overview:
Receive-side word-alignment and sync controller sitting between the deserializer and the 8b10b decoder. It takes unaligned 10-bit raw chunks, hunts for the comma pattern, locks a bit offset, and tracks running disparity and code errors. It also runs a lock/loss-of-sync state machine and drives the decoder's data_i/enable_i.

Parameters:
COMMA_CNT, 3, commas at the locked offset (including the first) required to reach SYNC; range 1..15
ERR_MAX, 4, error count in SYNC that forces loss of sync; range 1..15
GOOD_CLR, 4, consecutive good words that decrement the error count by one; range 1..15

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
raw_i  in  10  unaligned raw chunk; raw_i[9] is the first-received bit
raw_valid_i  in  1  raw_i is valid this cycle
data_o  out  10  aligned word to the decoder's data_i, abcdei order, data_o[9]=a
enable_o  out  1  to the decoder's enable_i; high for one cycle per aligned word in SYNC
sync_o  out  1  high while in SYNC
comma_o  out  1  the word on data_o is a comma at the locked offset
slip_o  out  4  locked bit offset, 0..9
disp_err_o  out  1  the word on data_o failed the disparity check

Behaviour:
- One clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values: all outputs 0; state HUNT; prev_q=0; rd_q=negative; all counters 0.
- When raw_valid_i=0, all state holds; enable_o, comma_o and disp_err_o are 0 next cycle; data_o holds.
- Window on each valid cycle:
  - win = {prev_q, raw_i} (20 bits); then prev_q <= raw_i.
  - Candidate word at offset k = win[19-k -: 10], k=0..9.
  - Comma at k: win[19-k -: 7] is 7'b0011111 or 7'b1100000.
- Disparity check on the aligned word w, with p = popcount(w):
  - p=5: good; rd unchanged.
  - p=6: good only if rd negative; rd <= positive.
  - p=4: good only if rd positive; rd <= negative.
  - Any other case is an error. rd <= positive if p>5, negative if p<5, unchanged if p=5.
- Latency: data_o, comma_o, disp_err_o and enable_o are registered one cycle after the valid edge that completes the word.
- HUNT:
  - Search offsets 0..9; the lowest matching offset wins.
  - On a match: slip_o <= k, comma_cnt <= 1. rd is set from that word's popcount (p>5 positive, p<5 negative, p=5 unchanged). Go to VERIFY, or straight to SYNC if COMMA_CNT=1.
  - With no match, stay in HUNT.
  - enable_o=0.
- VERIFY:
  - Comma at slip_o: comma_cnt++. When comma_cnt reaches COMMA_CNT, go to SYNC with err_cnt=0 and good_cnt=0.
  - Comma at a different offset, or a disparity error at slip_o: go to HUNT.
  - enable_o=0.
- SYNC:
  - Every valid cycle: enable_o=1, data_o=the aligned word.
  - An error is a disparity error, or a comma at an offset other than slip_o. On an error: err_cnt++, good_cnt=0.
  - On a good word: good_cnt++. When good_cnt reaches GOOD_CLR: good_cnt=0 and, if err_cnt>0, err_cnt--.
  - When err_cnt reaches ERR_MAX: go to HUNT, sync_o=0 next cycle. The word that caused the loss is still presented with enable_o=1 and disp_err_o=1.
- sync_o and comma_o are asserted and cleared in the same cycle as the corresponding data_o.
- Reset asserted mid-operation returns every output and counter to its reset value immediately, with no clock required.

Optional Feature:
RX_LOS_COUNT_EN
- Defined: adds output los_cnt_o[7:0], an 8-bit saturating count (stops at 255) of SYNC->HUNT transitions; reset 0.
- Not defined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Offset 0 lock:
  - Stimulus: stream 0011111010, 1010101010, 1100000101, 1010101010, ... (K28.5 alternating RD-/RD+, separated by D21.5).
  - Response: slip_o=0. sync_o rises on the cycle data_o carries the 3rd comma. enable_o=1 with data_o=1100000101 or 0011111010 as sent. disp_err_o stays 0.
- Offset 3 lock: same stream delayed by 3 bits -> slip_o=3; data_o matches the unshifted words; sync_o=1 after 3 commas.
- Loss of sync: in SYNC, inject 4 consecutive 1110111010 (popcount 7) -> disp_err_o=1 on each; sync_o=0 after the 4th; state is HUNT; enable_o=0 afterwards.
- Error recovery: in SYNC, inject 1 bad word, then 4 good words, then 3 more bad words -> sync_o stays 1 because err_cnt peaks at 3. A 4th consecutive bad word then drops sync.
- Gaps and reset:
  - raw_valid_i low for 5 cycles in SYNC: outputs hold, enable_o=0, sync_o stays 1.
  - rst_ni low mid-SYNC: sync_o, enable_o, data_o and slip_o go to 0 asynchronously.
- Misaligned comma: in VERIFY with slip_o=0, a comma at offset 5 -> return to HUNT, then relock at 5 once 3 commas are seen at offset 5. With RX_LOS_COUNT_EN defined, a SYNC loss bumps los_cnt_o 0->1.

Source files
------------

// File: rtl/rx_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rx_sync_ctrl
// Brief    : 8b10b comma alignment, running-disparity check and lock/LOS FSM.
//            Optional macro RX_LOS_COUNT_EN adds los_cnt_o (SYNC->HUNT count).
// Revision : 1.0
// ============================================================================
module rx_sync_ctrl #(
  parameter int COMMA_CNT = 3,
  parameter int ERR_MAX   = 4,
  parameter int GOOD_CLR  = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [9:0] raw_i,
  input  logic       raw_valid_i,
  output logic [9:0] data_o,
  output logic       enable_o,
  output logic       sync_o,
  output logic       comma_o,
  output logic [3:0] slip_o,
`ifdef RX_LOS_COUNT_EN
  output logic [7:0] los_cnt_o,
`endif
  output logic       disp_err_o
);

  localparam logic [6:0] c_COMMA_P   = 7'b0011111;
  localparam logic [6:0] c_COMMA_N   = 7'b1100000;
  localparam logic [4:0] c_COMMA_CNT = 5'(COMMA_CNT);
  localparam logic [4:0] c_ERR_MAX   = 5'(ERR_MAX);
  localparam logic [4:0] c_GOOD_CLR  = 5'(GOOD_CLR);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_VERIFY = 2'd1,
    S_SYNC   = 2'd2
  } state_t;

  state_t     r_state;
  logic [9:0] r_prev;
  logic [9:0] r_data;
  logic       r_rd;
  logic       r_enable;
  logic       r_sync;
  logic       r_comma;
  logic       r_disp_err;
  logic [3:0] r_slip;
  logic [3:0] r_comma_cnt;
  logic [3:0] r_err_cnt;
  logic [3:0] r_good_cnt;
`ifdef RX_LOS_COUNT_EN
  logic [7:0] r_los_cnt;
`endif

  logic [19:0] w_win;
  logic [9:0]  w_word [10];
  logic [9:0]  w_comma;
  logic        w_hunt_hit;
  logic [3:0]  w_hunt_k;
  logic [3:0]  w_sel_k;
  logic [9:0]  w_word_sel;
  logic        w_comma_at;
  logic        w_comma_other;
  logic [3:0]  w_pop;
  logic        w_disp_err;
  logic        w_rd_nxt;
  logic [4:0]  w_comma_inc;
  logic [4:0]  w_err_inc;
  logic [4:0]  w_good_inc;

  assign w_win = {r_prev, raw_i};

  for (genvar k = 0; k < 10; k++) begin : g_off
    assign w_word[k]  = w_win[19-k -: 10];
    assign w_comma[k] = (w_win[19-k -: 7] == c_COMMA_P) || (w_win[19-k -: 7] == c_COMMA_N);
  end

  // Scan downwards so the lowest matching offset is the one left standing.
  always_comb begin
    w_hunt_hit = 1'b0;
    w_hunt_k   = '0;
    for (int k = 9; k >= 0; k--) begin
      if (w_comma[k]) begin
        w_hunt_hit = 1'b1;
        w_hunt_k   = 4'(k);
      end
    end
  end

  assign w_sel_k       = ((r_state == S_HUNT) && w_hunt_hit) ? w_hunt_k : r_slip;
  assign w_word_sel    = w_word[w_sel_k];
  assign w_comma_at    = w_comma[w_sel_k];
  assign w_comma_other = |(w_comma & ~(10'd1 << r_slip));
  assign w_pop         = 4'($countones(w_word_sel));
  assign w_comma_inc   = {1'b0, r_comma_cnt} + 5'd1;
  assign w_err_inc     = {1'b0, r_err_cnt} + 5'd1;
  assign w_good_inc    = {1'b0, r_good_cnt} + 5'd1;

  // r_rd: 1 = positive running disparity.
  always_comb begin
    w_disp_err = 1'b1;
    w_rd_nxt   = r_rd;
    case (w_pop)
      4'd5: w_disp_err = 1'b0;
      4'd6: begin
        w_disp_err = r_rd;
        w_rd_nxt   = 1'b1;
      end
      4'd4: begin
        w_disp_err = ~r_rd;
        w_rd_nxt   = 1'b0;
      end
      default: w_rd_nxt = (w_pop > 4'd5);
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_HUNT;
      r_prev      <= '0;
      r_data      <= '0;
      r_rd        <= 1'b0;
      r_enable    <= 1'b0;
      r_sync      <= 1'b0;
      r_comma     <= 1'b0;
      r_disp_err  <= 1'b0;
      r_slip      <= '0;
      r_comma_cnt <= '0;
      r_err_cnt   <= '0;
      r_good_cnt  <= '0;
`ifdef RX_LOS_COUNT_EN
      r_los_cnt   <= '0;
`endif
    end else begin
      r_enable   <= 1'b0;
      r_comma    <= 1'b0;
      r_disp_err <= 1'b0;
      if (raw_valid_i) begin
        r_prev  <= raw_i;
        r_data  <= w_word_sel;
        r_comma <= w_comma_at;
        case (r_state)
          S_HUNT: begin
            if (w_hunt_hit) begin
              r_slip      <= w_hunt_k;
              r_comma_cnt <= 4'd1;
              r_rd        <= w_rd_nxt;
              if (c_COMMA_CNT == 5'd1) begin
                r_state    <= S_SYNC;
                r_sync     <= 1'b1;
                r_err_cnt  <= '0;
                r_good_cnt <= '0;
              end else begin
                r_state <= S_VERIFY;
              end
            end
          end
          S_VERIFY: begin
            r_rd       <= w_rd_nxt;
            r_disp_err <= w_disp_err;
            if (w_comma_other || w_disp_err) begin
              r_state <= S_HUNT;
            end else if (w_comma_at) begin
              r_comma_cnt <= w_comma_inc[3:0];
              if (w_comma_inc >= c_COMMA_CNT) begin
                r_state    <= S_SYNC;
                r_sync     <= 1'b1;
                r_err_cnt  <= '0;
                r_good_cnt <= '0;
              end
            end
          end
          S_SYNC: begin
            r_enable   <= 1'b1;
            r_rd       <= w_rd_nxt;
            r_disp_err <= w_disp_err;
            if (w_disp_err || w_comma_other) begin
              r_good_cnt <= '0;
              if (w_err_inc >= c_ERR_MAX) begin
                r_state   <= S_HUNT;
                r_sync    <= 1'b0;
                r_err_cnt <= '0;
`ifdef RX_LOS_COUNT_EN
                if (r_los_cnt != 8'hFF) r_los_cnt <= r_los_cnt + 8'd1;
`endif
              end else begin
                r_err_cnt <= w_err_inc[3:0];
              end
            end else if (w_good_inc >= c_GOOD_CLR) begin
              r_good_cnt <= '0;
              if (r_err_cnt != 4'd0) r_err_cnt <= r_err_cnt - 4'd1;
            end else begin
              r_good_cnt <= w_good_inc[3:0];
            end
          end
          default: r_state <= S_HUNT;
        endcase
      end
    end
  end

  assign data_o     = r_data;
  assign enable_o   = r_enable;
  assign sync_o     = r_sync;
  assign comma_o    = r_comma;
  assign slip_o     = r_slip;
  assign disp_err_o = r_disp_err;
`ifdef RX_LOS_COUNT_EN
  assign los_cnt_o  = r_los_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rx_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_sync_ctrl
// Brief    : Directed, table-driven self-checking bench for rx_sync_ctrl.
// Revision : 1.0
// ============================================================================
module tb_rx_sync_ctrl;

  localparam logic [9:0] KN = 10'b0011111010;
  localparam logic [9:0] KP = 10'b1100000101;
  localparam logic [9:0] DW = 10'b1010101010;
  localparam logic [9:0] BW = 10'b1110111010;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [9:0] raw_i;
  logic       raw_valid_i;
  logic [9:0] data_o;
  logic       enable_o;
  logic       sync_o;
  logic       comma_o;
  logic [3:0] slip_o;
  logic       disp_err_o;
`ifdef RX_LOS_COUNT_EN
  logic [7:0] los_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;
  bit sq[$];

  typedef struct packed {
    logic [9:0] raw;
    logic       v;
    logic       chk_data;
    logic [9:0] data;
    logic       en;
    logic       sync;
    logic       comma;
    logic       disp;
    logic [3:0] slip;
  } vec_t;

  vec_t tbl [12];

  rx_sync_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .raw_i       (raw_i),
    .raw_valid_i (raw_valid_i),
    .data_o      (data_o),
    .enable_o    (enable_o),
    .sync_o      (sync_o),
    .comma_o     (comma_o),
    .slip_o      (slip_o),
`ifdef RX_LOS_COUNT_EN
    .los_cnt_o   (los_cnt_o),
`endif
    .disp_err_o  (disp_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [9:0] raw, input logic v);
    @(negedge clk);
    raw_i       = raw;
    raw_valid_i = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni      = 1'b0;
    raw_i       = '0;
    raw_valid_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic lock0(input string name);
    do_reset();
    push(KN, 1'b1);
    push(DW, 1'b1);
    push(KP, 1'b1);
    push(DW, 1'b1);
    push(KN, 1'b1);
    push(DW, 1'b1);
    chk({name, ".sync"}, int'(sync_o), 1);
  endtask

  task automatic add_bits(input logic [9:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sq.push_back(v[i]);
  endtask

  function automatic logic [9:0] pop_chunk();
    logic [9:0] c;
    for (int i = 9; i >= 0; i--) c[i] = sq.pop_front();
    return c;
  endfunction

  function automatic logic [9:0] wseq(input int i);
    if (i % 2 == 1) return DW;
    return (i % 4 == 0) ? KN : KP;
  endfunction

  initial begin
    logic [9:0] c;

    //            raw  v  chkd data  en sy cm de slip
    tbl[0]  = '{KN, 1, 0, 10'd0, 0, 0, 0, 0, 4'd0};
    tbl[1]  = '{DW, 1, 1, KN,    0, 0, 1, 0, 4'd0};
    tbl[2]  = '{KP, 1, 1, DW,    0, 0, 0, 0, 4'd0};
    tbl[3]  = '{DW, 1, 1, KP,    0, 0, 1, 0, 4'd0};
    tbl[4]  = '{KN, 1, 1, DW,    0, 0, 0, 0, 4'd0};
    tbl[5]  = '{DW, 1, 1, KN,    0, 1, 1, 0, 4'd0};
    tbl[6]  = '{KP, 1, 1, DW,    1, 1, 0, 0, 4'd0};
    tbl[7]  = '{DW, 1, 1, KP,    1, 1, 1, 0, 4'd0};
    tbl[8]  = '{KN, 1, 1, DW,    1, 1, 0, 0, 4'd0};
    tbl[9]  = '{DW, 1, 1, KN,    1, 1, 1, 0, 4'd0};
    tbl[10] = '{10'd0, 0, 1, KN, 0, 1, 0, 0, 4'd0};
    tbl[11] = '{KP, 1, 1, DW,    1, 1, 0, 0, 4'd0};

    rst_ni      = 1'b0;
    raw_i       = '0;
    raw_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.data", int'(data_o), 0);
    chk("rst.en", int'(enable_o), 0);
    chk("rst.sync", int'(sync_o), 0);
    chk("rst.comma", int'(comma_o), 0);
    chk("rst.slip", int'(slip_o), 0);
    chk("rst.disp", int'(disp_err_o), 0);
`ifdef RX_LOS_COUNT_EN
    chk("rst.los", int'(los_cnt_o), 0);
`endif
    @(negedge clk);
    rst_ni = 1'b1;

    for (int i = 0; i < 12; i++) begin
      push(tbl[i].raw, tbl[i].v);
      if (tbl[i].chk_data) chk($sformatf("v%0d.data", i), int'(data_o), int'(tbl[i].data));
      chk($sformatf("v%0d.en", i), int'(enable_o), int'(tbl[i].en));
      chk($sformatf("v%0d.sync", i), int'(sync_o), int'(tbl[i].sync));
      chk($sformatf("v%0d.comma", i), int'(comma_o), int'(tbl[i].comma));
      chk($sformatf("v%0d.disp", i), int'(disp_err_o), int'(tbl[i].disp));
      chk($sformatf("v%0d.slip", i), int'(slip_o), int'(tbl[i].slip));
    end

    // Four popcount-7 words in SYNC; each shows one valid cycle after it is sent.
    push(BW, 1'b1);
    chk("los1.data", int'(data_o), int'(KP));
    chk("los1.disp", int'(disp_err_o), 0);
    for (int i = 2; i <= 4; i++) begin
      push(BW, 1'b1);
      chk($sformatf("los%0d.disp", i), int'(disp_err_o), 1);
      chk($sformatf("los%0d.sync", i), int'(sync_o), 1);
    end
    push(DW, 1'b1);
    chk("los5.data", int'(data_o), int'(BW));
    chk("los5.disp", int'(disp_err_o), 1);
    chk("los5.en", int'(enable_o), 1);
    chk("los5.sync", int'(sync_o), 0);
`ifdef RX_LOS_COUNT_EN
    chk("los5.cnt", int'(los_cnt_o), 1);
`endif
    push(DW, 1'b1);
    chk("los6.en", int'(enable_o), 0);
    chk("los6.sync", int'(sync_o), 0);
    push(KN, 1'b1);
    chk("los7.en", int'(enable_o), 0);

    // One bad word, four good words, then four consecutive bad words.
    lock0("rec");
    push(BW, 1'b1);
    push(DW, 1'b1);
    chk("rec1.disp", int'(disp_err_o), 1);
    chk("rec1.sync", int'(sync_o), 1);
    repeat (3) push(DW, 1'b1);
    repeat (3) push(BW, 1'b1);
    push(BW, 1'b1);
    chk("rec3.disp", int'(disp_err_o), 1);
    chk("rec3.sync", int'(sync_o), 1);
    push(DW, 1'b1);
    chk("rec4.disp", int'(disp_err_o), 1);
    chk("rec4.en", int'(enable_o), 1);
    chk("rec4.sync", int'(sync_o), 0);

    lock0("gap");
    for (int i = 0; i < 5; i++) begin
      push(10'h3FF, 1'b0);
      chk($sformatf("gap%0d.en", i), int'(enable_o), 0);
      chk($sformatf("gap%0d.sync", i), int'(sync_o), 1);
      chk($sformatf("gap%0d.data", i), int'(data_o), int'(KN));
      chk($sformatf("gap%0d.comma", i), int'(comma_o), 0);
    end
    push(KP, 1'b1);
    chk("gapr.data", int'(data_o), int'(DW));
    chk("gapr.en", int'(enable_o), 1);

    // Same stream delayed by three bits.
    do_reset();
    sq.delete();
    add_bits(10'd0, 3);
    for (int i = 0; i < 12; i++) add_bits(wseq(i), 10);
    for (int j = 0; j <= 10; j++) begin
      c = pop_chunk();
      push(c, 1'b1);
      chk($sformatf("off3.%0d.sync", j), int'(sync_o), (j >= 5) ? 1 : 0);
      chk($sformatf("off3.%0d.en", j), int'(enable_o), (j >= 6) ? 1 : 0);
      if (j >= 1) begin
        chk($sformatf("off3.%0d.data", j), int'(data_o), int'(wseq(j - 1)));
        chk($sformatf("off3.%0d.slip", j), int'(slip_o), 3);
      end
    end

    // Reset dropped between clock edges.
    @(negedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst.sync", int'(sync_o), 0);
    chk("arst.en", int'(enable_o), 0);
    chk("arst.data", int'(data_o), 0);
    chk("arst.slip", int'(slip_o), 0);
    chk("arst.comma", int'(comma_o), 0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Lock starts at offset 0, then a 5-bit pad moves the commas to offset 5.
    do_reset();
    sq.delete();
    add_bits(KN, 10);
    add_bits(DW, 10);
    add_bits(10'b01010, 5);
    for (int i = 0; i < 10; i++) add_bits(wseq(i + 2), 10);
    for (int j = 0; j <= 10; j++) begin
      c = pop_chunk();
      push(c, 1'b1);
      if (j == 1) chk("mis1.slip", int'(slip_o), 0);
      if (j == 3) chk("mis3.sync", int'(sync_o), 0);
      if (j == 4) chk("mis4.slip", int'(slip_o), 0);
      if (j == 5) chk("mis5.slip", int'(slip_o), 5);
      if (j == 5) chk("mis5.data", int'(data_o), int'(KN));
      if (j == 8) chk("mis8.sync", int'(sync_o), 0);
      if (j == 9) begin
        chk("mis9.sync", int'(sync_o), 1);
        chk("mis9.data", int'(data_o), int'(KN));
        chk("mis9.comma", int'(comma_o), 1);
        chk("mis9.slip", int'(slip_o), 5);
      end
      if (j == 10) begin
        chk("mis10.en", int'(enable_o), 1);
        chk("mis10.data", int'(data_o), int'(DW));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
